// File: rtl/stat_pkg.sv
// Shared types and constants for the delta-statistics blocks.
// Word width, words per channel, header tag and scheduler states.
package stat_pkg;

  localparam int STAT_W       = 16;
  localparam int WORDS_PER_CH = 3;

  localparam logic [3:0] HDR_TAG = 4'hA;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

endpackage

// File: rtl/stat_readout_sched_if.sv
// Valid/ready readout stream toward the DAQ readout FIFO.
// master drives data/valid, slave drives ready.
interface stat_readout_sched_if;
  import stat_pkg::*;

  logic [STAT_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/live_edge.sv
// Registered live-gate edge detector, async active-high reset.
// Single-cycle rise/fall pulses relative to the previous sample.
module live_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic pre_live;

  // remember last sampled gate level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_live <= 1'b0;
    else     pre_live <= din;
  end

  assign rise = din & ~pre_live;
  assign fall = pre_live & ~din;

endmodule

// File: rtl/stat_readout_sched.sv
// End-of-spill snapshot and round-robin readout of all channels.
// Optional header word enabled by STAT_READOUT_HDR_EN.
module stat_readout_sched
  import stat_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_live,
  input  logic [16*NCH-1:0]     ch_ndelta,
  input  logic [16*NCH-1:0]     ch_et_raw,
  input  logic [16*NCH-1:0]     ch_veto_raw,
  stat_readout_sched_if.master  out,
  output logic                  busy,
  output logic                  overrun,
  output logic [STAT_W-1:0]     spill_cnt
);

`ifdef STAT_READOUT_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  localparam int NW = WORDS_PER_CH * NCH;
  localparam int W  = NW + HDR;
  localparam int IW = $clog2(W + 1);

  state_t state, state_d;

  logic [IW-1:0]     idx, idx_d;
  logic [STAT_W-1:0] snap [NW];
  logic [STAT_W-1:0] cur;
  logic              fall;
  logic              rise_unused;
  logic              cap;
  logic              done;

  live_edge u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (in_live),
    .rise (rise_unused),
    .fall (fall)
  );

  // next state: capture on fall, step index on each handshake
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cap     = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          cap     = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out.out_ready) begin
          if (idx == IW'(W - 1)) begin
            done    = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, index, counters and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      spill_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      if (done)
        spill_cnt <= spill_cnt + 1'b1;
      if (fall && state == SEND)
        overrun <= 1'b1;
    end
  end

  // snapshot bank, frozen outside the capture edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NW; i++)
        snap[i] <= '0;
    end else if (cap) begin
      for (int k = 0; k < NCH; k++) begin
        snap[WORDS_PER_CH*k]     <= ch_ndelta[16*k +: 16];
        snap[WORDS_PER_CH*k + 1] <= ch_et_raw[16*k +: 16];
        snap[WORDS_PER_CH*k + 2] <= ch_veto_raw[16*k +: 16];
      end
    end
  end

  // word mux: header (if built in) then snapshot in order
  always_comb begin
    cur = '0;
    for (int i = 0; i < NW; i++)
      if (idx == IW'(i + HDR))
        cur = snap[i];
`ifdef STAT_READOUT_HDR_EN
    if (idx == '0)
      cur = {HDR_TAG, spill_cnt[11:0]};
`endif
  end

  assign busy          = (state == SEND);
  assign out.out_valid = busy;
  assign out.out_data  = busy ? cur : '0;

endmodule

// File: tb/tb_stat_readout_sched.sv
// Randomised and directed bench for stat_readout_sched.
// Queue-based reference model, checked every cycle.
module tb_stat_readout_sched;

  localparam int NCH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_live = 1'b0;
  logic              ready = 1'b0;
  logic [16*NCH-1:0] ch_ndelta = '0;
  logic [16*NCH-1:0] ch_et_raw = '0;
  logic [16*NCH-1:0] ch_veto_raw = '0;
  logic              busy;
  logic              overrun;
  logic [15:0]       spill_cnt;

  stat_readout_sched_if bus ();
  assign bus.out_ready = ready;

  stat_readout_sched #(.NCH(NCH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_live     (in_live),
    .ch_ndelta   (ch_ndelta),
    .ch_et_raw   (ch_et_raw),
    .ch_veto_raw (ch_veto_raw),
    .out         (bus.master),
    .busy        (busy),
    .overrun     (overrun),
    .spill_cnt   (spill_cnt)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  bit          m_pre = 1'b0;
  logic [15:0] q [$];
  logic [15:0] log_q [$];
  logic [15:0] m_spill = '0;
  bit          m_ovr = 1'b0;
  logic [15:0] exp_w [3*NCH];

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // model: a readout is a queue of words built on a fall while idle
  always @(posedge clk) begin
    bit fall;
    bit was_busy;
    if (rst) begin
      m_pre = 1'b0;
      q.delete();
      m_spill = '0;
      m_ovr = 1'b0;
    end else begin
      fall = m_pre && !in_live;
      was_busy = (q.size() > 0);
      if (was_busy) begin
        if (fall) m_ovr = 1'b1;
        if (ready) begin
          log_q.push_back(q.pop_front());
          if (q.size() == 0) m_spill++;
        end
      end else if (fall) begin
`ifdef STAT_READOUT_HDR_EN
        q.push_back({4'hA, m_spill[11:0]});
`endif
        for (int k = 0; k < NCH; k++) begin
          q.push_back(ch_ndelta[16*k +: 16]);
          q.push_back(ch_et_raw[16*k +: 16]);
          q.push_back(ch_veto_raw[16*k +: 16]);
        end
      end
      m_pre = in_live;
    end
    #1;
    chk("out_valid", {15'd0, bus.out_valid}, {15'd0, q.size() > 0});
    chk("out_data", bus.out_data, (q.size() > 0) ? q[0] : 16'h0);
    chk("busy", {15'd0, busy}, {15'd0, q.size() > 0});
    chk("overrun", {15'd0, overrun}, {15'd0, m_ovr});
    chk("spill_cnt", spill_cnt, m_spill);
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fall_live();
    @(negedge clk) in_live = 1'b1;
    @(negedge clk) in_live = 1'b0;
  endtask

  task automatic set_pattern();
    ch_ndelta = '0;
    ch_et_raw = '0;
    ch_veto_raw = '0;
    for (int k = 1; k < NCH; k++) begin
      ch_ndelta[16*k +: 16] = 16'(k);
      ch_et_raw[16*k +: 16] = 16'(k);
      ch_veto_raw[16*k +: 16] = 16'(k);
    end
    ch_ndelta[15:0] = 16'h0005;
    ch_et_raw[15:0] = 16'h0123;
    ch_veto_raw[15:0] = 16'h00F0;
  endtask

  // compare model log against the hand-written word list
  task automatic check_log(string nm, logic [15:0] hdr_spill);
    int off;
    off = 0;
`ifdef STAT_READOUT_HDR_EN
    off = 1;
    chk({nm, "_hdr"}, (log_q.size() > 0) ? log_q[0] : 16'hxxxx,
        {4'hA, hdr_spill[11:0]});
`else
    chk({nm, "_hdrspill"}, hdr_spill, hdr_spill);
`endif
    chk({nm, "_len"}, 16'(log_q.size()), 16'(3*NCH + off));
    for (int i = 0; i < 3*NCH; i++)
      if (i + off < log_q.size())
        chk({nm, "_word"}, log_q[i + off], exp_w[i]);
  endtask

  initial begin
    exp_w[0] = 16'h0005;
    exp_w[1] = 16'h0123;
    exp_w[2] = 16'h00F0;
    for (int k = 1; k < NCH; k++)
      for (int j = 0; j < 3; j++)
        exp_w[3*k + j] = 16'(k);

    set_pattern();
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // full-rate readout
    ready = 1'b1;
    log_q.delete();
    fall_live();
    cyc(16);
    chk("t1_w0", log_q[0 + (log_q.size() > 12 ? 1 : 0)], 16'h0005);
    check_log("t1", 16'd0);
    chk("t1_spill", m_spill, 16'd1);

    // stalling ready 1,0,0,...
    log_q.delete();
    fall_live();
    for (int i = 0; i < 45; i++) begin
      @(negedge clk) ready = (i % 3 == 0);
    end
    ready = 1'b1;
    cyc(2);
    check_log("t2", 16'd1);
    chk("t2_spill", m_spill, 16'd2);

    // second fall while busy
    ready = 1'b0;
    log_q.delete();
    fall_live();
    cyc(3);
    fall_live();
    cyc(3);
    chk("t3_ovr", {15'd0, m_ovr}, 16'd1);
    ready = 1'b1;
    cyc(16);
    check_log("t3", 16'd2);
    chk("t3_spill", m_spill, 16'd3);

    // inputs change right after the snapshot
    log_q.delete();
    fall_live();
    @(negedge clk);
    ch_ndelta = '1;
    ch_et_raw = '1;
    ch_veto_raw = '1;
    cyc(16);
    check_log("t4", 16'd3);
    set_pattern();

    // reset mid-readout
    fall_live();
    cyc(5);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("t5_spill0", m_spill, 16'd0);
    chk("t5_ovr0", {15'd0, m_ovr}, 16'd0);
    log_q.delete();
    fall_live();
    cyc(16);
    check_log("t5", 16'd0);
    chk("t5_spill", m_spill, 16'd1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) in_live = ~in_live;
      ready = ($urandom_range(0, 3) != 0);
      ch_ndelta = {$urandom, $urandom};
      ch_et_raw = {$urandom, $urandom};
      ch_veto_raw = {$urandom, $urandom};
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    in_live = 1'b1;
    ready = 1'b1;
    cyc(60);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/stat_readout_sched.md
# stat_readout_sched

End-of-spill readout scheduler for the delta-statistics channels. It watches the live gate, snapshots every channel's delta counter, last ET and last veto pattern on the live falling edge, and serialises the snapshot onto a single 16-bit valid/ready stream toward the DAQ readout FIFO. It sits between the array of per-channel delta-statistics blocks and the readout link. It arbitrates that one stream among all channels in fixed round-robin order, so the channels never contend for the link.

## Interface
- NCH, 4: number of delta-statistics channels, 1..16
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- in_live  input  1  live gate, same signal that drives the channels
- ch_ndelta  input  16*NCH  per-channel delta count; channel k at bits [16k+15:16k]
- ch_et_raw  input  16*NCH  per-channel last delta ET, same packing
- ch_veto_raw  input  16*NCH  per-channel last veto pattern, same packing
- out_data  output  16  readout word
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts the word when high with out_valid
- busy  output  1  snapshot held or readout in progress
- overrun  output  1  sticky: a live falling edge arrived while busy
- spill_cnt  output  16  number of completed readouts, wraps 0xFFFF to 0x0000

## Operation
- Edge detect:
  - pre_live is a register; it resets to 0.
  - The fall condition is pre_live=1 and in_live=0, sampled at the same clk edge.
- States are IDLE, SEND.
- IDLE:
  - On fall, capture all 3*NCH input words into the snapshot bank.
  - Clear the word index and go to SEND.
  - Set busy.
- SEND:
  - out_valid=1 and out_data = the current word.
  - On out_valid and out_ready, advance the index.
  - The last word accepted goes to IDLE, clears busy and increments spill_cnt.
- Word order: ch0 ndelta, ch0 et_raw, ch0 veto_raw, ch1 ndelta, … up to ch(NCH-1) veto_raw.
- out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- out_data is 0 whenever out_valid=0.
- Boundary behaviour:
  - A fall while busy sets overrun. The new data is discarded and the current readout is not disturbed.
  - overrun clears only on rst.
  - A rising live edge during SEND has no effect; the snapshot is frozen.
  - The channel inputs changing during SEND have no effect.
  - out_ready held high: one word per cycle, no bubbles.
  - rst asserted mid-readout aborts at once. No partial readout is resumed.
- Reset values:
  - out_data=0, out_valid=0, busy=0, overrun=0, spill_cnt=0.
  - State IDLE, pre_live=0, snapshot bank=0.

## Timing
- Fall is sampled at edge T. The snapshot is captured at T. busy=1 and out_valid=1 are visible after T, i.e. the first word is presented in cycle T+1.
- With out_ready constantly 1, the last word is accepted at edge T+W, where W = 3*NCH, or 3*NCH+1 with the header.
  - busy falls and spill_cnt increments after T+W.
  - A new fall is accepted from edge T+W+1.
- A fall at edge T+W itself counts as busy and sets overrun.
- overrun asserts the cycle after the offending edge.

## Configuration
- STAT_READOUT_HDR_EN:
  - When defined, a header word {4'hA, spill_cnt[11:0]} is sent before ch0 ndelta.
  - spill_cnt in the header is the value before the increment.
  - W = 3*NCH+1.
- When undefined, no header is sent and W = 3*NCH.

## Structure
- Shared package stat_pkg holds:
  - STAT_W=16
  - WORDS_PER_CH=3
  - HDR_TAG=4'hA
  - the state enum {IDLE, SEND}
- One sub-module, live_edge: a registered edge detector with async reset. It outputs single-cycle rise and fall pulses and is reused by the other statistics blocks.
- The snapshot bank and word mux stay in the top module.

## Test plan
- NCH=4, ch0 inputs ndelta=5, et=0x0123, veto=0x00F0, other channels at their index. Live 1→0 with out_ready=1 → 12 words in order starting 0x0005, 0x0123, 0x00F0, one per cycle from T+1, then spill_cnt=1 and busy=0.
- Same stimulus with out_ready toggling 1,0,0,1,… → no word lost or duplicated, out_data stable while stalled, exactly 12 handshakes.
- Second live fall during SEND (ready held 0) → overrun=1, readout still delivers the first snapshot, spill_cnt=1 after completion.
- Channel inputs changed to 0xFFFF right after the snapshot → streamed words still carry the captured values.
- rst pulsed after word 5 → out_valid=0, spill_cnt=0 immediately. The next live fall produces a complete 12-word readout from word 0.
- STAT_READOUT_HDR_EN defined, three spills → headers 0xA000, 0xA001, 0xA002, each followed by 12 data words.
